// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and colour helpers for the VGA pipeline.
package vga_timing_pkg;

  localparam int unsigned VGA_CLK_DIV     = 4;
  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_VIS_START = 144;
  localparam int unsigned VGA_H_VIS_END   = 784;
  localparam int unsigned VGA_V_TOTAL     = 525;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_VIS_START = 35;
  localparam int unsigned VGA_V_VIS_END   = 515;

  localparam logic [11:0] RGB_BLACK = 12'h000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Unsigned half-open window test: lo <= v < hi.
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Pixel-rate enable: a free-running 0..CLK_DIV-1 divider, pix_en on the last count.
module pixel_clk_en #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_l,
  output logic pix_en
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // Next divider value: wrap after the last count.
  always_comb begin
    div_d = div_q;
    if (div_q == DIV_MAX) begin
      div_d = {DW{1'b0}};
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Divider register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      div_q <= {DW{1'b0}};
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_en = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: scan counters, visible-area flag, frame strobes and
// a one-pixel registered output stage keeping sync and colour aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_VIS_START = VGA_H_VIS_START,
  parameter int unsigned H_VIS_END   = VGA_H_VIS_END,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_VIS_START = VGA_V_VIS_START,
  parameter int unsigned V_VIS_END   = VGA_V_VIS_END
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        vblank_start,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_VS      = 10'(H_VIS_START);
  localparam logic [9:0] H_VE      = 10'(H_VIS_END);
  localparam logic [9:0] V_VS      = 10'(V_VIS_START);
  localparam logic [9:0] V_VE      = 10'(V_VIS_END);
  // vblank_start can only fire if vCount ever reaches V_VIS_END.
  localparam logic       HAS_VBLANK = (V_VIS_END < V_TOTAL);
  localparam logic [9:0] V_VB_PRE   = 10'(V_VIS_END - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       frame_tick_q, frame_tick_d;
  logic       vblank_start_q, vblank_start_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  rgb_t       rgb_q, rgb_d;
  logic       bright_c;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .clk    (clk),
    .rst_l  (rst_l),
    .pix_en (pix_en)
  );

  assign bright_c = in_window(hcount_q, H_VS, H_VE) && in_window(vcount_q, V_VS, V_VE);

  // Next raster position, strobes and output stage; everything moves on pix_en only.
  always_comb begin
    hcount_d       = hcount_q;
    vcount_d       = vcount_q;
    frame_tick_d   = 1'b0;
    vblank_start_d = 1'b0;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    rgb_d          = rgb_q;
    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 10'd0;
        if (vcount_q == V_LAST) begin
          vcount_d     = 10'd0;
          frame_tick_d = 1'b1;
        end else begin
          vcount_d       = vcount_q + 10'd1;
          vblank_start_d = HAS_VBLANK && (vcount_q == V_VB_PRE);
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
      // Output stage uses the pre-update position, giving a one-pixel lag.
      hsync_d = !(hcount_q < H_SYNC_W);
      vsync_d = !(vcount_q < V_SYNC_W);
      rgb_d   = bright_c ? rgb_t'(rgb_in) : rgb_t'(RGB_BLACK);
    end else begin
      hcount_d = hcount_q;
    end
  end

  // State registers with synchronous active-low reset (sync outputs idle high).
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      hcount_q       <= 10'd0;
      vcount_q       <= 10'd0;
      frame_tick_q   <= 1'b0;
      vblank_start_q <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      rgb_q          <= rgb_t'(RGB_BLACK);
    end else begin
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      frame_tick_q   <= frame_tick_d;
      vblank_start_q <= vblank_start_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      rgb_q          <= rgb_d;
    end
  end

  assign hCount       = hcount_q;
  assign vCount       = vcount_q;
  assign bright       = bright_c;
  assign frame_tick   = frame_tick_q;
  assign vblank_start = vblank_start_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign vgaR         = rgb_q.r;
  assign vgaG         = rgb_q.g;
  assign vgaB         = rgb_q.b;

endmodule
